seq_mag_comp: RTL
=================

// Module: seq_mag_comp
// PURPOSE
//  Parametrised, iterative magnitude comparator. Successor to the fixed 4-bit combinational comparator.
//  Compares two WIDTH-bit operands CHUNK bits per cycle, most-significant chunk first.
//  Stops early at the first unequal chunk.
//  Sits behind a start/done handshake so wide operands are compared without a long combinational chain.
// PARAMETERS
//  WIDTH  16  operand width in bits; must be a multiple of CHUNK
//  CHUNK  4   bits compared per cycle; 1 <= CHUNK <= WIDTH
//  (derived) NCH = WIDTH/CHUNK chunks; index register is $clog2(NCH) bits, minimum 1
// PORTS
//  clk           input   1      clock, rising edge
//  rst_n         input   1      asynchronous, active-low reset
//  start         input   1      request; sampled only in IDLE
//  a             input   WIDTH  operand A; latched on accepted start
//  b             input   WIDTH  operand B; latched on accepted start
//  signed_mode   input   1      only with CMP_SIGNED_EN; latched on accepted start
//  busy          output  1      high while a comparison is in progress (state RUN)
//  done          output  1      one-cycle pulse; result valid
//  greater_than  output  1      A > B; registered, held until next done
//  less_than     output  1      A < B; registered, held until next done
//  equal_to      output  1      A == B; registered, held until next done
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; busy=0, done=0, greater_than=0, less_than=0, equal_to=0
//   - operand and index registers cleared
//   - Reset mid-RUN abandons the comparison: no done pulse, no result update.
//  FSM: IDLE, RUN.
//   - IDLE, start=1: latch a, b (and signed_mode); idx <= NCH-1; go to RUN; busy=1 from next cycle.
//   - IDLE, start=0: hold.
//   - RUN, each edge: compare chunk idx of A and B (bits idx*CHUNK +: CHUNK).
//     * Chunk unequal: set gt/lt from the chunk; eq=0; done=1; go to IDLE.
//     * Chunk equal and idx==0: gt=0, lt=0, eq=1; done=1; go to IDLE.
//     * Otherwise: idx <= idx-1; stay in RUN.
//   - start while busy=1 is ignored (not queued). start in the same cycle done=1 (state IDLE) is accepted.
//  Latency:
//   - Start accepted at edge E0. done is high for the cycle after edge E0+k.
//   - k = position of the first differing chunk counted from the MSB (1..NCH), or k = NCH when equal.
//   - Best case 1, worst case NCH.
//   - CHUNK==WIDTH: always 1 cycle.
//  Outputs:
//   - Exactly one of gt/lt/eq is 1 after the first done.
//   - All three are 0 only between reset and the first done.
//   - Results update only on the done edge.
//   - busy and done are never 1 in the same cycle.
// CONFIGURATION
//  CMP_SIGNED_EN defined:
//   - signed_mode port present.
//   - signed_mode=1: operands are two's complement; the MSB of the top chunk is inverted on both operands before comparing.
//   - signed_mode=0: unsigned.
//  CMP_SIGNED_EN undefined:
//   - No signed_mode port; always unsigned.
// TESTING (WIDTH=16, CHUNK=4)
//  1. a=16'h1234, b=16'h1234, start 1 cycle -> busy 4 cycles; done after 4th RUN edge; eq=1, gt=0, lt=0.
//  2. a=16'h9000, b=16'h1FFF -> done 1 cycle after start; gt=1.
//     Then a=16'h1233, b=16'h1234 -> done after 4 cycles; lt=1.
//  3. a=16'h12F0, b=16'h1200 -> early exit at chunk 1: done 3 cycles after start; gt=1.
//  4. start held high throughout run of case 1; new operands applied while busy -> ignored.
//     A second comparison starts only on the cycle done=1.
//  5. rst_n low for 1 cycle mid-RUN -> busy=0, outputs 0 immediately; no done pulse.
//     Next start completes normally.
//  6. (CMP_SIGNED_EN) a=16'h8000, b=16'h0001: signed_mode=1 -> lt=1; signed_mode=0 -> gt=1.

Source files
------------

// File: rtl/seq_mag_comp.sv
// Iterative magnitude comparator: compares WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
// Optional two's-complement mode is enabled by defining CMP_SIGNED_EN (adds the signed_mode port).
module seq_mag_comp #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
   input  logic             signed_mode,
`endif
   output logic             busy,
   output logic             done,
   output logic             greater_than,
   output logic             less_than,
   output logic             equal_to
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [IW-1:0]    idx_q;
   logic             busy_q, done_q, gt_q, lt_q, eq_q;
   logic [WIDTH-1:0] smask;
   logic [CHUNK-1:0] ca, cb;

   // Signed compare reduces to unsigned once the sign bits are flipped at latch time.
`ifdef CMP_SIGNED_EN
   assign smask = WIDTH'(signed_mode) << (WIDTH - 1);
`else
   assign smask = '0;
`endif

   always_comb begin
      ca = CHUNK'(a_q >> (idx_q * CHUNK));
      cb = CHUNK'(b_q >> (idx_q * CHUNK));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a ^ smask;
                  b_q     <= b ^ smask;
                  idx_q   <= IW'(NCH - 1);
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (ca != cb) begin
                  gt_q    <= (ca > cb);
                  lt_q    <= (ca < cb);
                  eq_q    <= 1'b0;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (idx_q == '0) begin
                  gt_q    <= 1'b0;
                  lt_q    <= 1'b0;
                  eq_q    <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  idx_q <= idx_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign greater_than = gt_q;
   assign less_than    = lt_q;
   assign equal_to     = eq_q;

endmodule
